// File: rtl/wishbone_pipeline_target.sv
`default_nettype none
// ============================================================================
// Module      : wishbone_pipeline_target
// Description : Pipelined Wishbone B4 target front-end with in-order request
//               queue, valid/ready backend issue, and backend response timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module wishbone_pipeline_target #(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int GRANULARITY    = 8,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int SEL_WIDTH     = DATA_WIDTH / GRANULARITY
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CYC,
  input  logic                     STB,
  input  logic                     WE,
  input  logic [ADDRESS_WIDTH-1:0] ADDR,
  input  logic [DATA_WIDTH-1:0]    DAT_ToTarget,
  input  logic [SEL_WIDTH-1:0]     SEL,
  output logic                     STALL,
  output logic                     ACK,
  output logic                     ERR,
  output logic [DATA_WIDTH-1:0]    DAT_ToInitiator,
  output logic                     REQ_VALID,
  input  logic                     REQ_READY,
  output logic                     REQ_WE,
  output logic [ADDRESS_WIDTH-1:0] REQ_ADDR,
  output logic [DATA_WIDTH-1:0]    REQ_DAT,
  output logic [SEL_WIDTH-1:0]     REQ_SEL,
  input  logic                     RSP_VALID,
  input  logic [DATA_WIDTH-1:0]    RSP_DAT,
  input  logic                     RSP_ERR
);

  localparam int c_ptr_w   = $clog2(DEPTH);
  localparam int c_cnt_w   = $clog2(DEPTH) + 1;
  localparam int c_tmr_w   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int c_entry_w = 1 + ADDRESS_WIDTH + DATA_WIDTH + SEL_WIDTH;
  localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);
  localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT_CYCLES - 1);
  localparam logic               c_tmr_en   = (TIMEOUT_CYCLES != 0);

  logic [c_entry_w-1:0] r_mem [DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr, r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count, r_outstanding, r_issued, r_discard;
  logic [c_tmr_w-1:0]   r_timer;
  logic                 r_ack, r_err;
  logic [DATA_WIDTH-1:0] r_dat;

  logic w_accept, w_pop, w_has_issued, w_disc_dec, w_rsp_take, w_timeout, w_retire;
  logic [c_cnt_w-1:0] w_issued_nxt, w_discard_nxt;

  assign STALL           = (r_outstanding == c_depth) | (r_discard != '0);
  assign REQ_VALID       = CYC & (r_count != '0);
  assign {REQ_WE, REQ_ADDR, REQ_DAT, REQ_SEL} = r_mem[r_rd_ptr];
  assign ACK             = r_ack;
  assign ERR             = r_err;
  assign DAT_ToInitiator = r_dat;

  assign w_accept     = CYC & STB & ~STALL;
  assign w_pop        = REQ_VALID & REQ_READY;
  // A request being issued this cycle may already be answered in the same cycle.
  assign w_has_issued = (r_issued != '0) | w_pop;
  assign w_disc_dec   = RSP_VALID & (r_discard != '0);
  assign w_rsp_take   = RSP_VALID & (r_discard == '0) & w_has_issued;
  assign w_timeout    = c_tmr_en & w_has_issued & ~RSP_VALID & (r_timer == c_tmr_last);
  assign w_retire     = w_rsp_take | w_timeout;

  assign w_issued_nxt  = r_issued + c_cnt_w'(w_pop) - c_cnt_w'(w_retire);
  assign w_discard_nxt = r_discard - c_cnt_w'(w_disc_dec) + c_cnt_w'(w_timeout);

  always_ff @(posedge CLK) begin
    if (w_accept) r_mem[r_wr_ptr] <= {WE, ADDR, DAT_ToTarget, SEL};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_issued      <= '0;
      r_discard     <= '0;
      r_timer       <= '0;
      r_ack         <= 1'b0;
      r_err         <= 1'b0;
      r_dat         <= '0;
    end else begin
      if (!w_has_issued || RSP_VALID || w_timeout) r_timer <= '0;
      else                                         r_timer <= r_timer + 1'b1;

      r_ack <= CYC & w_rsp_take & ~RSP_ERR;
      r_err <= CYC & ((w_rsp_take & RSP_ERR) | w_timeout);
      if (CYC && w_rsp_take && !RSP_ERR) r_dat <= RSP_DAT;

      if (!CYC) begin
        // Everything already sent to the backend must be absorbed before a new cycle starts.
        r_wr_ptr      <= '0;
        r_rd_ptr      <= '0;
        r_count       <= '0;
        r_outstanding <= '0;
        r_issued      <= '0;
        r_discard     <= w_discard_nxt + w_issued_nxt;
      end else begin
        if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count       <= r_count + c_cnt_w'(w_accept) - c_cnt_w'(w_pop);
        r_outstanding <= r_outstanding + c_cnt_w'(w_accept) - c_cnt_w'(w_retire);
        r_issued      <= w_issued_nxt;
        r_discard     <= w_discard_nxt;
      end
    end
  end

endmodule
`default_nettype wire
